// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter states and frame constants.
// Imported by the arbiter and its round-robin picker.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_GAP
  } arb_state_e;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_W     = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Finds the first valid requester after last_grant.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    last_grant,
  output logic             any_valid,
  output logic [IW-1:0]    winner
);

  logic [N_REQ-1:0]   mask;
  logic [2*N_REQ-1:0] dbl;
  int                 start;

  // Low half keeps only slots at/after start; high half wraps around.
  always_comb begin
    if (int'(last_grant) >= N_REQ - 1) begin
      start = 0;
    end else begin
      start = int'(last_grant) + 1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (i >= start);
    end
    dbl = {valid, valid & mask};
    winner = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (dbl[i]) begin
        winner = IW'(i % N_REQ);
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit sequencer.
// Latches the winning byte and enforces an optional idle gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = UART_DATA_W,
  parameter int GAP_TICKS = 1,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    baud_tick,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic                    start_tx,
  output logic [DATA_W-1:0]       tx_data,
  output logic [IW-1:0]           grant_idx,
  output logic                    tx_active
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] pick_data;
  logic [IW-1:0]     grant_q;
  logic [IW-1:0]     last_q;
  logic [IW-1:0]     winner;
  logic [GW-1:0]     gap_q;
  logic              any_valid;
  logic              take;
  logic              frame_end;
  logic              gap_tick;
  logic              gap_end;

  uart_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (last_q),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  assign take      = (state_q == ARB_IDLE) && any_valid && !tx_busy;
  assign frame_end = (state_q == ARB_WAIT) && tx_done;
  assign gap_tick  = (state_q == ARB_GAP) && baud_tick;
  assign gap_end   = gap_tick && (gap_q == GW'(1));

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IW'(k) == winner) begin
        pick_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (take) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (tx_done) begin
          state_d = (GAP_TICKS == 0) ? ARB_IDLE : ARB_GAP;
        end
      end
      ARB_GAP:   if (gap_end) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Pointer resets to the last slot so requester 0 wins first.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ARB_IDLE;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        data_q  <= pick_data;
        grant_q <= winner;
        last_q  <= winner;
      end
      if (frame_end && (GAP_TICKS != 0)) begin
        gap_q <= GW'(GAP_TICKS);
      end else if (gap_tick) begin
        gap_q <= gap_q - GW'(1);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ARB_ISSUE) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign start_tx  = (state_q == ARB_ISSUE);
  assign tx_data   = data_q;
  assign grant_idx = grant_q;
  assign tx_active = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: three instances with gaps 1, 0 and 2,
// a sequencer model each, and a start_tx scoreboard.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] dat;
  } exp_t;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [1:0]  e;
  } vec_t;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            baud_tick;
  logic [2:0][3:0]  rv;
  logic [2:0][31:0] rd;
  logic [2:0][3:0]  rr;
  logic [2:0]       st;
  logic [2:0][7:0]  td;
  logic [2:0][1:0]  gi;
  logic [2:0]       ta;
  logic [2:0]       busy_f;
  logic [2:0]       inj;
  logic [2:0]       done_m;

  exp_t sbq[$];
  int   cur;
  int   checks = 0;
  int   errors = 0;
  int   armed[3];
  int   cyc[3];
  int   ticks[3];
  logic [7:0] hold_dat;
  int   bcnt = 0;
  vec_t tbl[10];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GT = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
    logic       busy;
    logic       done;
    logic [3:0] cnt;

    uart_tx_arbiter #(
      .N_REQ(4),
      .DATA_W(8),
      .GAP_TICKS(GT)
    ) u_dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .req_valid (rv[g]),
      .req_data  (rd[g]),
      .req_ready (rr[g]),
      .baud_tick (baud_tick),
      .tx_busy   (busy | busy_f[g]),
      .tx_done   (done | inj[g]),
      .start_tx  (st[g]),
      .tx_data   (td[g]),
      .grant_idx (gi[g]),
      .tx_active (ta[g])
    );

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        busy <= 1'b0;
        done <= 1'b0;
        cnt  <= '0;
      end else begin
        done <= 1'b0;
        if (st[g]) begin
          busy <= 1'b1;
          cnt  <= 4'd10;
        end else if (busy && baud_tick) begin
          if (cnt == 4'd1) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
          cnt <= cnt - 4'd1;
        end
      end
    end

    assign done_m[g] = done;
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout, got no event expected one", nm);
  endtask

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bcnt++;
      baud_tick = (bcnt % 4 == 0);
    end
  end

  // Scoreboard and gap/latency monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!arst_n) begin
        armed[i] = 0;
      end else begin
        cyc[i]++;
        if (baud_tick) ticks[i]++;
        if (st[i]) begin
          if (i != cur || sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: inst %0d got start expected none", i);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("grant_idx", 32'(gi[i]), 32'(e.idx));
            chk("tx_data", 32'(td[i]), 32'(e.dat));
            chk("req_ready", 32'(rr[i]), 32'(4'b0001 << e.idx));
            hold_dat = e.dat;
          end
          if (armed[i] != 0) begin
            chk("gap_ticks", 32'(ticks[i] >= gap_of(i)), 32'd1);
            if (i == 1) chk("b2b_cycles", 32'(cyc[i]), 32'd2);
          end
          armed[i] = 0;
        end else if (ta[i] && i == cur) begin
          chk("tx_data_hold", 32'(td[i]), 32'(hold_dat));
        end
        if (done_m[i]) begin
          armed[i] = 1;
          cyc[i]   = 0;
          ticks[i] = 0;
        end
      end
    end
  end

  task automatic wait_idle(input int i);
    bit ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (!ta[i]) ok = 1;
    end
    if (!ok) timeout("wait_idle");
  endtask

  task automatic wait_sb();
    bit ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (sbq.size() == 0) ok = 1;
    end
    if (!ok) timeout("wait_scoreboard");
  endtask

  task automatic push(input logic [1:0] idx, input logic [31:0] d);
    exp_t x;
    x.idx = idx;
    x.dat = d[int'(idx)*8 +: 8];
    sbq.push_back(x);
  endtask

  task automatic one_frame(input int i, input logic [3:0] v,
                           input logic [31:0] d, input logic [1:0] e);
    @(posedge clk);
    #1;
    rd[i] = d;
    rv[i] = v;
    push(e, d);
    @(posedge clk);
    @(negedge clk);
    chk("latency", 32'(st[i]), 32'd1);
    @(posedge clk);
    #1;
    rv[i] = '0;
    wait_idle(i);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    rv = '0;
    rd = '0;
    busy_f = '0;
    inj = '0;
    cur = 0;
    hold_dat = '0;
    arst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      armed[i] = 0;
      cyc[i]   = 0;
      ticks[i] = 0;
    end
    tbl[0] = '{4'b0001, 32'h443322A5, 2'd0};
    tbl[1] = '{4'b0101, 32'h443322A5, 2'd2};
    tbl[2] = '{4'b0101, 32'h443322A5, 2'd0};
    tbl[3] = '{4'b1001, 32'h443322A5, 2'd3};
    tbl[4] = '{4'b1001, 32'h443322A5, 2'd0};
    tbl[5] = '{4'b0110, 32'h443322A5, 2'd1};
    tbl[6] = '{4'b1111, 32'h443322A5, 2'd2};
    tbl[7] = '{4'b0011, 32'h443322A5, 2'd0};
    tbl[8] = '{4'b1000, 32'h443322A5, 2'd3};
    tbl[9] = '{4'b0010, 32'h443322A5, 2'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start_tx", 32'(st[0]), 32'd0);
    chk("rst_req_ready", 32'(rr[0]), 32'd0);
    chk("rst_tx_active", 32'(ta[0]), 32'd0);
    chk("rst_tx_data", 32'(td[0]), 32'd0);
    chk("rst_grant_idx", 32'(gi[0]), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    for (int n = 0; n < 10; n++) begin
      one_frame(0, tbl[n].v, tbl[n].d, tbl[n].e);
    end

    // tx_busy holds the arbiter in IDLE.
    @(posedge clk);
    #1;
    busy_f[0] = 1'b1;
    rv[0] = 4'b1000;
    repeat (6) begin
      @(negedge clk);
      chk("busy_no_start", 32'(st[0]), 32'd0);
      chk("busy_no_ready", 32'(rr[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    busy_f[0] = 1'b0;
    push(2'd3, rd[0]);
    @(posedge clk);
    @(negedge clk);
    chk("busy_release_start", 32'(st[0]), 32'd1);
    @(posedge clk);
    #1;
    rv[0] = '0;
    wait_idle(0);

    // Reset in the middle of WAIT.
    @(posedge clk);
    #1;
    rv[0] = 4'b0010;
    push(2'd1, rd[0]);
    wait_sb();
    @(posedge clk);
    #1;
    rv[0] = '0;
    repeat (4) @(negedge clk);
    chk("pre_rst_active", 32'(ta[0]), 32'd1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_start_tx", 32'(st[0]), 32'd0);
    chk("mid_rst_req_ready", 32'(rr[0]), 32'd0);
    chk("mid_rst_tx_active", 32'(ta[0]), 32'd0);
    chk("mid_rst_tx_data", 32'(td[0]), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    rd[0] = 32'h44332211;
    rv[0] = 4'b1111;
    push(2'd0, rd[0]);
    push(2'd1, rd[0]);
    wait_sb();
    @(posedge clk);
    #1;
    rv[0] = '0;
    wait_idle(0);

    // Fairness with all four requesters re-raising.
    pulse_reset();
    rd[0] = 32'h44332211;
    rv[0] = 4'b1111;
    push(2'd0, rd[0]);
    push(2'd1, rd[0]);
    push(2'd2, rd[0]);
    push(2'd3, rd[0]);
    push(2'd0, rd[0]);
    wait_sb();
    @(posedge clk);
    #1;
    rv[0] = '0;
    wait_idle(0);

    // Back-to-back frames with no gap.
    cur = 1;
    @(posedge clk);
    #1;
    rd[1] = 32'h44332211;
    rv[1] = 4'b0100;
    repeat (3) push(2'd2, rd[1]);
    wait_sb();
    @(posedge clk);
    #1;
    rv[1] = '0;
    wait_idle(1);

    // Two-tick gap with spurious tx_done in GAP and IDLE.
    cur = 2;
    @(posedge clk);
    #1;
    rd[2] = 32'h44332211;
    rv[2] = 4'b0100;
    push(2'd2, rd[2]);
    push(2'd2, rd[2]);
    begin
      bit ok = 0;
      for (int n = 0; n < 2000 && !ok; n++) begin
        @(negedge clk);
        if (done_m[2]) ok = 1;
      end
      if (!ok) timeout("wait_tx_done");
    end
    @(posedge clk);
    #1;
    inj[2] = 1'b1;
    @(posedge clk);
    #1;
    inj[2] = 1'b0;
    @(negedge clk);
    chk("gap_ignores_done", 32'(ta[2]), 32'd1);
    wait_sb();
    @(posedge clk);
    #1;
    rv[2] = '0;
    wait_idle(2);
    @(posedge clk);
    #1;
    inj[2] = 1'b1;
    @(posedge clk);
    #1;
    inj[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ignores_done", 32'(ta[2]), 32'd0);
    end

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d pending starts expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
